// File: rtl/des_round_engine.sv
// Iterative DES round engine.
// Takes a block already split into IP halves and a key already through PC-1,
// runs the 16 Feistel rounds ROUNDS_PER_CYCLE at a time, and presents the
// swapped pre-output {R16, L16}. Subkeys are derived on the fly by rotating
// the C/D halves (left for encrypt, right for decrypt).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (ready only while idle)
//   in_mode               0 = encrypt, 1 = decrypt
//   in_L, in_R            block halves after IP
//   in_key                {C0, D0} after PC-1
//   out_valid / out_ready result handshake (valid only while done)
//   out_data              {R16, L16}, held until accepted
//   busy                  high while rounds are being computed
module des_round_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [31:0] in_L,
  input  logic [31:0] in_R,
  input  logic [55:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int ITERS = 16 / ROUNDS_PER_CYCLE;
  localparam logic [3:0] LAST_RND = 4'((ITERS - 1) * ROUNDS_PER_CYCLE);
  localparam logic [3:0] RND_STEP = 4'(ROUNDS_PER_CYCLE);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rounds
    $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // S-boxes: 64 nibbles each, row-major, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  // Permutation tables in DES bit numbering (1 = MSB).
  localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC2_TAB [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                  23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Rotation for 0-based round index; decrypt round 0 reuses C0/D0 (= C16/D16).
  function automatic logic [1:0] rot_amt(input logic dec, input logic [3:0] rnd);
    logic [1:0] a;
    case (rnd)
      4'd0:              a = dec ? 2'd0 : 2'd1;
      4'd1, 4'd8, 4'd15: a = 2'd1;
      default:           a = 2'd2;
    endcase
    return a;
  endfunction

  function automatic logic [27:0] rot28(input logic dec, input logic [27:0] x,
                                        input logic [1:0] amt);
    logic [27:0] y;
    case ({dec, amt})
      3'b001:  y = {x[26:0], x[27]};
      3'b010:  y = {x[25:0], x[27:26]};
      3'b101:  y = {x[0], x[27:1]};
      3'b110:  y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  // E is regular: output group j takes input bits 4j..4j+5 with wrap-around.
  function automatic logic [47:0] expand(input logic [31:0] r);
    logic [33:0] x;
    logic [47:0] e;
    x = {r[0], r, r[31]};
    e = '0;
    for (int j = 0; j < 8; j++) e[6'(47 - 6 * j) -: 6] = x[6'(33 - 4 * j) -: 6];
    return e;
  endfunction

  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
    logic [5:0]   pos;
    logic [255:0] t;
    pos = 6'd63 - {b[5], b[0], b[4:1]};
    t   = SBOX[n] >> {pos, 2'b00};
    return t[3:0];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    x = expand(r) ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) s[5'(31 - 4 * j) -: 4] = sbox(3'(j), x[6'(47 - 6 * j) -: 6]);
    p = '0;
    for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_TAB[i])];
    return p;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    k = '0;
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return k;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_p0, r_p0;
  logic [27:0] c_p0, d_p0;
  logic        mode_p0;
  logic [3:0]  rnd_p0;
  logic [63:0] out_p1;
  logic        last_iter;

  logic [31:0] l_ch [ROUNDS_PER_CYCLE+1];
  logic [31:0] r_ch [ROUNDS_PER_CYCLE+1];
  logic [27:0] c_ch [ROUNDS_PER_CYCLE+1];
  logic [27:0] d_ch [ROUNDS_PER_CYCLE+1];

  assign l_ch[0] = l_p0;
  assign r_ch[0] = r_p0;
  assign c_ch[0] = c_p0;
  assign d_ch[0] = d_p0;

  // ---- p0 -> p0: ROUNDS_PER_CYCLE rounds chained combinationally ----
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    logic [1:0]  amt;
    logic [47:0] k;
    assign amt         = rot_amt(mode_p0, rnd_p0 + 4'(g));
    assign c_ch[g+1]   = rot28(mode_p0, c_ch[g], amt);
    assign d_ch[g+1]   = rot28(mode_p0, d_ch[g], amt);
    assign k           = pc2({c_ch[g+1], d_ch[g+1]});
    assign l_ch[g+1]   = r_ch[g];
    assign r_ch[g+1]   = l_ch[g] ^ feistel(r_ch[g], k);
  end

  assign last_iter = (rnd_p0 == LAST_RND);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- input capture -> p0 working registers -> p1 result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      l_p0    <= '0;
      r_p0    <= '0;
      c_p0    <= '0;
      d_p0    <= '0;
      mode_p0 <= 1'b0;
      rnd_p0  <= '0;
      out_p1  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rnd_p0 <= '0;
          if (in_valid) begin
            l_p0    <= in_L;
            r_p0    <= in_R;
            c_p0    <= in_key[55:28];
            d_p0    <= in_key[27:0];
            mode_p0 <= in_mode;
          end
        end
        RUN: begin
          l_p0 <= l_ch[ROUNDS_PER_CYCLE];
          r_p0 <= r_ch[ROUNDS_PER_CYCLE];
          c_p0 <= c_ch[ROUNDS_PER_CYCLE];
          d_p0 <= d_ch[ROUNDS_PER_CYCLE];
          // Counter never carries past 15: it is cleared on the final iteration.
          rnd_p0 <= last_iter ? 4'd0 : rnd_p0 + RND_STEP;
          if (last_iter) out_p1 <= {r_ch[ROUNDS_PER_CYCLE], l_ch[ROUNDS_PER_CYCLE]};
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_p1;

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: five instances (1, 2, 4, 8, 16 rounds per cycle)
// driven in lockstep, checked against a table-driven DES model that builds the
// full subkey schedule up front and reverses it for decryption.
module tb_des_round_engine;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_mode, out_ready;
  logic [31:0] in_L, in_R;
  logic [55:0] in_key;
  logic        ir [5];
  logic        ov [5];
  logic        bz [5];
  logic [63:0] od [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    des_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]), .in_mode(in_mode),
      .in_L(in_L), .in_R(in_R), .in_key(in_key), .out_valid(ov[g]),
      .out_ready(out_ready), .out_data(od[g]), .busy(bz[g]));
  end

  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                              16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [31:0] fmod(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    logic [5:0]  b;
    int          row, col;
    for (int i = 0; i < 48; i++) e[47 - i] = r[32 - E_T[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = e[47 - 6 * j -: 6];
      row = 2 * int'(b[5]) + int'(b[0]);
      col = int'(b[4:1]);
      s[31 - 4 * j -: 4] = 4'(SB[j * 64 + row * 16 + col]);
    end
    for (int i = 0; i < 32; i++) p[31 - i] = s[32 - P_T[i]];
    return p;
  endfunction

  function automatic logic [63:0] des_model(input logic [31:0] l0, input logic [31:0] r0,
                                            input logic [55:0] key, input logic dec);
    logic [47:0] ks [16];
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [31:0] l, r, t;
    c = key[55:28];
    d = key[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SH[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[i][47 - j] = cd[56 - PC2_T[j]];
    end
    l = l0;
    r = r0;
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ fmod(r, dec ? ks[15 - i] : ks[i]);
      l = t;
    end
    return {r, l};
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d observed %h expected %h", tag, d, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] l, input logic [31:0] r, input logic [55:0] key,
                        input logic m, input string tag);
    for (int d = 0; d < 5; d++) chk({tag, " in_ready"}, d, 64'(ir[d]), 64'd1);
    in_L = l; in_R = r; in_key = key; in_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_L = ~l; in_R = ~r; in_key = ~key; in_mode = ~m;
  endtask

  // Called one cycle after the accepting edge; returns in the cycle where the
  // slowest instance first shows out_valid.
  task automatic wait_result(input logic [63:0] exp, input string tag);
    int seen [5];
    int n;
    bit all;
    for (int d = 0; d < 5; d++) begin
      seen[d] = 0;
      chk({tag, " busy"}, d, 64'(bz[d]), 64'd1);
    end
    n = 1;
    while (1) begin
      all = 1'b1;
      for (int d = 0; d < 5; d++) begin
        if (seen[d] == 0 && ov[d]) begin
          seen[d] = n;
          chk({tag, " data"}, d, od[d], exp);
          chk({tag, " latency"}, d, 64'(n), 64'(16 / (1 << d) + 1));
        end
        if (seen[d] == 0) all = 1'b0;
      end
      if (all || n >= 40) break;
      @(posedge clk); #1;
      n++;
    end
    for (int d = 0; d < 5; d++)
      if (seen[d] == 0) chk({tag, " timeout out_valid"}, d, 64'(ov[d]), 64'd1);
  endtask

  task automatic xact(input logic [31:0] l, input logic [31:0] r, input logic [55:0] key,
                      input logic m, input logic [63:0] exp, input string tag);
    out_ready = 1'b1;
    launch(l, r, key, m, tag);
    wait_result(exp, tag);
    @(posedge clk); #1;
    for (int d = 0; d < 5; d++) begin
      chk({tag, " ready after"}, d, 64'(ir[d]), 64'd1);
      chk({tag, " valid after"}, d, 64'(ov[d]), 64'd0);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 5; d++) begin
      chk({tag, " in_ready"}, d, 64'(ir[d]), 64'd1);
      chk({tag, " out_valid"}, d, 64'(ov[d]), 64'd0);
      chk({tag, " busy"}, d, 64'(bz[d]), 64'd0);
      chk({tag, " out_data"}, d, od[d], 64'd0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] kl, kr, rl, rr;
    logic [55:0] kkey, rkey;
    logic [63:0] kexp, rexp;
    logic        rm;
    kl   = 32'hCC00CCFF;
    kr   = 32'hF0AAF0AA;
    kkey = {28'hF0CCAAF, 28'h556678F};
    kexp = 64'h0A4CD995_43423234;

    // Reset wins over a simultaneous in_valid / out_ready.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_mode = 1'b0;
    in_L = kl; in_R = kr; in_key = kkey;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check_idle("post reset");

    // Known answers.
    xact(kl, kr, kkey, 1'b0, kexp, "kat_enc");
    xact(32'h0A4CD995, 32'h43423234, kkey, 1'b1, {kl, kr}, "kat_dec");

    // Backpressure for 20 cycles with an ignored in_valid in the middle.
    out_ready = 1'b0;
    launch(kl, kr, kkey, 1'b0, "bp");
    wait_result(kexp, "bp");
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        in_valid = 1'b1; in_L = 32'h12345678; in_R = 32'h9ABCDEF0; in_mode = 1'b1;
      end
      if (c == 10) in_valid = 1'b0;
      for (int d = 0; d < 5; d++) begin
        chk("bp hold valid", d, 64'(ov[d]), 64'd1);
        chk("bp hold data", d, od[d], kexp);
        chk("bp hold in_ready", d, 64'(ir[d]), 64'd0);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 5; d++) begin
      chk("bp release in_ready", d, 64'(ir[d]), 64'd1);
      chk("bp release out_valid", d, 64'(ov[d]), 64'd0);
      chk("bp release busy", d, 64'(bz[d]), 64'd0);
    end
    xact(32'h0A4CD995, 32'h43423234, kkey, 1'b1, {kl, kr}, "after_bp");

    // Reset in the first RUN iteration discards the block.
    launch(kl, kr, kkey, 1'b0, "midrst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("midrst");
    xact(kl, kr, kkey, 1'b0, kexp, "after_rst");

    // Random cross-check with round trip through the opposite mode.
    for (int i = 0; i < 1000; i++) begin
      rl   = $urandom;
      rr   = $urandom;
      rkey = {24'($urandom), $urandom};
      rm   = 1'($urandom_range(0, 1));
      rexp = des_model(rl, rr, rkey, rm);
      xact(rl, rr, rkey, rm, rexp, "rand");
      xact(rexp[63:32], rexp[31:0], rkey, ~rm, {rl, rr}, "rtrip");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
